// File: rtl/fcp6_pkg.sv
// Shared definitions for the FCP6 requester arbiter: FSM encodings,
// header field positions and the default master timeout.
package fcp6_pkg;

  typedef logic [2:0] fcp6_state_t;

  localparam fcp6_state_t ST_IDLE      = 3'd0;
  localparam fcp6_state_t ST_LAUNCH    = 3'd1;
  localparam fcp6_state_t ST_WAIT_BUSY = 3'd2;
  localparam fcp6_state_t ST_WAIT_DONE = 3'd3;
  localparam fcp6_state_t ST_COMPLETE  = 3'd4;

  localparam int HDR_WR_BIT  = 0;
  localparam int HDR_LEN_MSB = 3;
  localparam int HDR_LEN_LSB = 1;

  localparam int DEF_TIMEOUT = 255;

  // A zero-length transfer would leave the master waiting for bytes that never come.
  function automatic logic hdr_valid(input logic [7:0] hdr);
    return |hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/fcp6_req_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot winner starting the search
// just after the previously served index.
module rr_picker #(
  parameter  int N  = 4,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  pick,
  output logic          any
);

  int idx;

  // Walk from farthest to nearest so the nearest set request overwrites the rest.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fcp6_req_arbiter.sv
// Round-robin arbiter sharing the single FCP6 master between NUM_REQ local
// requesters; captures the winner's request, launches the master, watches for timeout.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no transaction; pick a winner when any req is set
// ST_LAUNCH    | one cycle; m_start if header valid, else flag error
// ST_WAIT_BUSY | waiting for master to raise m_busy
// ST_WAIT_DONE | waiting for master to drop m_busy
// ST_COMPLETE  | one cycle; done/err/rdata to the granted requester
module fcp6_req_arbiter
  import fcp6_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_header,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 m_start,
  output logic [7:0]           m_header,
  output logic [7:0]           m_wdata,
  input  logic                 m_busy,
  input  logic [7:0]           m_rdata
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  fcp6_state_t        state;
  logic [LW-1:0]      last;
  logic [LW-1:0]      win;
  logic [NUM_REQ-1:0] gnt_q;
  logic [7:0]         hdr_q;
  logic [7:0]         wdata_q;
  logic               err_q;
  logic [CW-1:0]      cnt;

  logic [NUM_REQ-1:0] pick;
  logic               any;
  logic [LW-1:0]      pick_idx;
  logic [7:0]         pick_hdr;
  logic [7:0]         pick_wdata;
  logic [CW-1:0]      cnt_inc;
  logic               tmo_hit;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    pick_idx   = '0;
    pick_hdr   = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx   = LW'(i);
        pick_hdr   = req_header[i*8 +: 8];
        pick_wdata = req_wdata[i*8 +: 8];
      end
    end
  end

  // The counter spans both wait states; abort happens after TIMEOUT wait cycles.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  assign tmo_hit = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      last    <= LW'(NUM_REQ - 1);
      win     <= '0;
      gnt_q   <= '0;
      hdr_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt_q   <= pick;
            win     <= pick_idx;
            hdr_q   <= pick_hdr;
            wdata_q <= pick_wdata;
            err_q   <= 1'b0;
            state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt <= '0;
          if (hdr_valid(hdr_q)) begin
            state <= ST_WAIT_BUSY;
          end else begin
            err_q <= 1'b1;
            state <= ST_COMPLETE;
          end
        end
        ST_WAIT_BUSY: begin
          cnt <= cnt_inc;
          if (m_busy) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= ST_COMPLETE;
          end
        end
        ST_WAIT_DONE: begin
          cnt <= cnt_inc;
          if (!m_busy) begin
            state <= ST_COMPLETE;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          last  <= win;
          gnt_q <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign m_header = hdr_q;
  assign m_wdata  = wdata_q;
  assign m_start  = (state == ST_LAUNCH) && hdr_valid(hdr_q);
  assign done     = (state == ST_COMPLETE) ? gnt_q : '0;
  assign err      = (state == ST_COMPLETE) && err_q;
  assign rdata    = ((state == ST_COMPLETE) && !err_q && !hdr_q[HDR_WR_BIT]) ? m_rdata : 8'h00;

endmodule

// File: tb/tb_fcp6_req_arbiter.sv
// Self-checking bench for fcp6_req_arbiter with a small behavioural FCP6 master/slave
// and a scoreboard of expected completions.
module tb_fcp6_req_arbiter;

  localparam int N   = 4;
  localparam int TMO = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_header;
  logic [8*N-1:0]   req_wdata;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic             err;
  logic [7:0]       rdata;
  logic             m_start;
  logic [7:0]       m_header;
  logic [7:0]       m_wdata;
  logic             m_busy;
  logic [7:0]       m_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fcp6_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_header (req_header),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .m_start    (m_start),
    .m_header   (m_header),
    .m_wdata    (m_wdata),
    .m_busy     (m_busy),
    .m_rdata    (m_rdata)
  );

  // Behavioural master + slave: busy for busy_len cycles after m_start,
  // writes land in slave_mem0, reads return saved_data[0] = 88.
  logic       force_idle = 1'b0;
  int         busy_len   = 1;
  int         bcnt;
  logic [7:0] slave_mem0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy     <= 1'b0;
      m_rdata    <= 8'h00;
      bcnt       <= 0;
      slave_mem0 <= 8'h00;
    end else if (m_start && !force_idle) begin
      m_busy <= 1'b1;
      bcnt   <= busy_len;
      if (!m_header[0]) m_rdata <= 8'd88;
    end else if (m_busy) begin
      if (bcnt <= 1) begin
        m_busy <= 1'b0;
        if (m_header[0]) slave_mem0 <= m_wdata;
      end
      bcnt <= bcnt - 1;
    end
  end

  typedef struct {
    int         idx;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] hdr;
    int         t_done;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] sq[$];

  exp_t       e;
  logic [7:0] h;
  logic [N-1:0] exp_d;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_start) begin
        checks++;
        if (sq.size() == 0) begin
          failures++;
          $display("FAIL m_start_unexpected: got m_start=1 header=%h, required no start", m_header);
        end else begin
          h = sq.pop_front();
          if (m_header !== h) begin
            failures++;
            $display("FAIL m_start_header: got %h, required %h", m_header, h);
          end
        end
      end
      if (done !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected: got done=%b err=%b at cyc=%0d, required no done", done, err, cyc);
        end else begin
          e = sb.pop_front();
          exp_d = '0;
          exp_d[e.idx] = 1'b1;
          if (done !== exp_d || err !== e.err || rdata !== e.rdata || m_header !== e.hdr ||
              (e.t_done >= 0 && cyc != e.t_done)) begin
            failures++;
            $display("FAIL done_txn: got done=%b err=%b rdata=%h hdr=%h cyc=%0d, required done=%b err=%b rdata=%h hdr=%h cyc=%0d",
                     done, err, rdata, m_header, cyc, exp_d, e.err, e.rdata, e.hdr, e.t_done);
          end
        end
      end else if (err !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL err_without_done: got err=%b, required 0", err);
      end
    end
  end

  task automatic issue(input int i, input logic [7:0] hd, input logic [7:0] wd);
    req_header[i*8 +: 8] = hd;
    req_wdata[i*8 +: 8]  = wd;
    req[i]               = 1'b1;
  endtask

  task automatic expect_txn(input int i, input logic [7:0] hd, input logic er,
                            input logic [7:0] rd, input int td, input bit st);
    exp_t x;
    x.idx = i; x.err = er; x.rdata = rd; x.hdr = hd; x.t_done = td;
    sb.push_back(x);
    if (st) sq.push_back(hd);
  endtask

  // Requesters drop req on the cycle their done is seen.
  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while ((req != '0 || gnt != '0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      req = req & ~done;
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_budget: got %0d cycles with %0d pending, required completion", name, n, sb.size());
      sb.delete();
      req = '0;
    end
    checks++;
    if (sq.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_start: got %0d starts outstanding, required 0", name, sq.size());
      sq.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (gnt !== '0 || done !== '0 || err !== 1'b0 || rdata !== 8'h00 ||
        m_start !== 1'b0 || m_header !== 8'h00 || m_wdata !== 8'h00) begin
      failures++;
      $display("FAIL %s_outputs: got gnt=%b done=%b err=%b rdata=%h m_start=%b m_header=%h m_wdata=%h, required all 0",
               name, gnt, done, err, rdata, m_start, m_header, m_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_header = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_release");
    mon_en = 1'b1;
  endtask

  task automatic test_round_robin();
    int t0;
    busy_len = 2;
    t0 = cyc;
    issue(0, 8'h03, 8'hA0);
    issue(1, 8'h02, 8'h00);
    issue(2, 8'h05, 8'hA2);
    issue(3, 8'h04, 8'h00);
    expect_txn(0, 8'h03, 1'b0, 8'h00, t0 + 5,  1'b1);
    expect_txn(1, 8'h02, 1'b0, 8'd88, t0 + 11, 1'b1);
    expect_txn(2, 8'h05, 1'b0, 8'h00, t0 + 17, 1'b1);
    expect_txn(3, 8'h04, 1'b0, 8'd88, t0 + 23, 1'b1);
    wait_quiet(100, "rr_all");
    // last is now 3: serve 1 alone, then 1 and 3 together must go 3 then 1.
    t0 = cyc;
    issue(1, 8'h06, 8'h00);
    expect_txn(1, 8'h06, 1'b0, 8'd88, t0 + 5, 1'b1);
    wait_quiet(50, "rr_one");
    t0 = cyc;
    issue(1, 8'h02, 8'h00);
    issue(3, 8'h07, 8'h3C);
    expect_txn(3, 8'h07, 1'b0, 8'h00, t0 + 5,  1'b1);
    expect_txn(1, 8'h02, 1'b0, 8'd88, t0 + 11, 1'b1);
    wait_quiet(50, "rr_follow");
  endtask

  task automatic test_write();
    int t0;
    busy_len = 1;
    t0 = cyc;
    issue(0, 8'h05, 8'h10);
    expect_txn(0, 8'h05, 1'b0, 8'h00, t0 + 4, 1'b1);
    wait_quiet(50, "write");
    checks++;
    if (slave_mem0 !== 8'h10) begin
      failures++;
      $display("FAIL write_slave_mem: got %h, required 10", slave_mem0);
    end
  endtask

  task automatic test_read();
    int t0;
    busy_len = 1;
    t0 = cyc;
    issue(1, 8'h04, 8'h00);
    expect_txn(1, 8'h04, 1'b0, 8'd88, t0 + 4, 1'b1);
    wait_quiet(50, "read_min");
    busy_len = 3;
    t0 = cyc;
    issue(2, 8'h0E, 8'h00);
    expect_txn(2, 8'h0E, 1'b0, 8'd88, t0 + 6, 1'b1);
    wait_quiet(50, "read_long");
  endtask

  task automatic test_timeout();
    int t0;
    force_idle = 1'b1;
    t0 = cyc;
    issue(2, 8'h05, 8'h33);
    expect_txn(2, 8'h05, 1'b1, 8'h00, t0 + 1 + TMO + 1, 1'b1);
    wait_quiet(400, "timeout_wr");
    // Read that times out must still return 0 despite a stale m_rdata.
    t0 = cyc;
    issue(3, 8'h04, 8'h00);
    expect_txn(3, 8'h04, 1'b1, 8'h00, t0 + 1 + TMO + 1, 1'b1);
    wait_quiet(400, "timeout_rd");
    force_idle = 1'b0;
  endtask

  task automatic test_invalid();
    int t0;
    busy_len = 1;
    t0 = cyc;
    issue(3, 8'h01, 8'h77);
    expect_txn(3, 8'h01, 1'b1, 8'h00, t0 + 2, 1'b0);
    wait_quiet(50, "invalid_wr");
    t0 = cyc;
    issue(1, 8'h00, 8'h00);
    expect_txn(1, 8'h00, 1'b1, 8'h00, t0 + 2, 1'b0);
    wait_quiet(50, "invalid_rd");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int k = 0;
    int t0;
    busy_len = 10;
    issue(0, 8'h05, 8'h5A);
    sq.push_back(8'h05);
    while (k < 2 && n < 50) begin
      @(negedge clk);
      if (m_busy) k++;
      n++;
    end
    checks++;
    if (k < 2) begin
      failures++;
      $display("FAIL reset_mid_busy: got %0d busy cycles, required 2", k);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check_outputs_zero("reset_mid");
    rst = 1'b0;
    busy_len = 1;
    repeat (2) @(negedge clk);
    t0 = cyc;
    issue(0, 8'h05, 8'h11);
    issue(2, 8'h04, 8'h00);
    expect_txn(0, 8'h05, 1'b0, 8'h00, t0 + 4, 1'b1);
    expect_txn(2, 8'h04, 1'b0, 8'd88, t0 + 9, 1'b1);
    wait_quiet(50, "reset_mid_after");
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_header = '0;
    req_wdata = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_write();
    test_read();
    test_timeout();
    test_invalid();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required finish before 200000");
    $fatal(1);
  end

endmodule
